alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Multi-cycle RV32M multiply/divide unit, parametrised in data width, sitting beside the single-cycle ALU in the execute stage.
- Accepts one operation per valid/ready handshake.
- Iterates one bit per cycle (shift-add multiply, restoring divide).
- Returns a single-cycle out_valid pulse with the result held stable afterwards.
- The pipeline stalls on busy.

Parameters:
- DATA_WIDTH, 32, operand and result width (W); must be even and at least 8.
- OPCODE_LENGTH, 3, width of the op select.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- in_valid  input  1  operation request.
- in_ready  output  1  high only in IDLE.
- op  input  OPCODE_LENGTH  operation select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  input  DATA_WIDTH  rs1 / dividend.
- SrcB  input  DATA_WIDTH  rs2 / divisor.
- flush  input  1  abort the in-flight operation (branch mispredict/trap).
- busy  output  1  high in CALC, FIX and DONE.
- out_valid  output  1  one-cycle result strobe.
- ALUResult  output  DATA_WIDTH  result, held until the next accepted operation.

Behaviour:
- Reset values: state IDLE, in_ready=1, busy=0, out_valid=0, ALUResult=0, all internal registers 0.
- Reset asserted in any state returns to IDLE next edge; any partial result is discarded.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_valid=1 latches op, SrcA and SrcB.
  - Operands are converted to magnitudes per signedness:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: A signed, B unsigned.
    - Others: both unsigned.
  - Result sign is recorded, counter loaded with W, next state CALC.
  - Special cases skip CALC and go straight to DONE:
    - Divide by zero (SrcB==0, ops 1xx): quotient = all ones; remainder = SrcA.
    - Signed overflow (DIV/REM with SrcA = 1 followed by zeros, SrcB = all ones): DIV returns SrcA; REM returns 0.
- CALC: one iteration per cycle; counter decrements; at count 1 → FIX.
  - Multiply: 2W-bit product register, add-shift on multiplier LSB.
  - Divide: remainder shift-left, trial subtract, quotient bit set if non-negative.
- FIX (1 cycle): negate per the recorded sign, then select the result.
  - Multiply sign = sign(A) XOR sign(B), applied to the 2W product.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
  - Result selection: MUL low W bits; MULH/MULHSU/MULHU high W bits; DIV/DIVU quotient; REM/REMU remainder.
  - Next state DONE.
- DONE (1 cycle): out_valid=1, ALUResult updated, next state IDLE.
- Latency, counted from the accept edge to the out_valid cycle:
  - Normal operation: W+2 cycles (34 for W=32).
  - Special case: 1 cycle.
- Back-to-back: a new accept is possible on the cycle after DONE, since in_ready is high again in IDLE.
- in_valid while busy is ignored; the requester must hold the request until in_ready.
- flush:
  - In CALC or FIX: return to IDLE next edge, no out_valid, ALUResult unchanged.
  - In DONE: ignored (result already committed).
  - In IDLE: blocks acceptance that cycle.
  - flush and reset together: reset wins (same effect).
- All arithmetic is modulo 2^W; no flags are produced.

Decomposition:
- Package alu_muldiv_pkg contains:
  - muldiv_op_e enum (8 ops above).
  - state_e enum (IDLE, CALC, FIX, DONE).
  - Helper functions is_div(op), a_signed(op), b_signed(op).
- One natural sub-module: alu_muldiv_step, a combinational single-iteration datapath (add-shift / trial-subtract), parametrised on DATA_WIDTH.

Test Plan:
- Reset mid-CALC (cycle 10 of DIVU 100/7) → next cycle in_ready=1, busy=0, no out_valid, ALUResult=0.
- MUL 0xFFFFFFFF×0xFFFFFFFF (W=32) → out_valid at cycle 34, ALUResult=0x00000001. MULH on the same operands → 0x00000000. MULHU → 0xFFFFFFFE.
- MULHSU SrcA=0xFFFFFFFF (−1), SrcB=2 → 0xFFFFFFFF. MUL 7×(−3) → 0xFFFFFFEB.
- DIV −7/2 → 0xFFFFFFFD (−3). REM −7/2 → 0xFFFFFFFF (−1). DIVU 100/7 → 14. REMU 100/7 → 2. Each with 34-cycle latency.
- DIV 5/0 → 0xFFFFFFFF in 1 cycle. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM on the same operands → 0.
- flush at cycle 20 of MUL, then immediate DIVU 9/3 → only one out_valid, value 3. in_valid held during busy is accepted exactly once.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// rtl/alu_muldiv_pkg.sv - shared types and op-decode helpers for the multiply/divide unit
package alu_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    // Divide-family ops share the trial-subtract datapath.
    function automatic logic is_div(input muldiv_op_e op);
        return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
    endfunction

    // Ops whose result is the remainder rather than the quotient.
    function automatic logic is_rem(input muldiv_op_e op);
        return (op inside {OP_REM, OP_REMU});
    endfunction

    // rs1 is treated as two's complement.
    function automatic logic a_signed(input muldiv_op_e op);
        return (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    endfunction

    // rs2 is treated as two's complement.
    function automatic logic b_signed(input muldiv_op_e op);
        return (op inside {OP_MULH, OP_DIV, OP_REM});
    endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// rtl/alu_muldiv_step.sv - one iteration of shift-add multiply or restoring divide
module alu_muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  div_mode,
    input  logic [DATA_WIDTH-1:0] hi,
    input  logic [DATA_WIDTH-1:0] lo,
    input  logic [DATA_WIDTH-1:0] operand,
    output logic [DATA_WIDTH-1:0] hi_next,
    output logic [DATA_WIDTH-1:0] lo_next
);

    localparam int W = DATA_WIDTH;

    logic [W:0] sum;
    logic [W:0] shifted;
    logic [W:0] diff;

    // Multiply: {hi,lo} is the product register with the multiplier draining out of lo.
    // Divide: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
    // The remainder is always below the divisor, so W+1 bits hold the trial difference.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(W+1){1'b0}});
        shifted = {hi, lo[W-1]};
        diff    = shifted - {1'b0, operand};
        hi_next = sum[W:1];
        lo_next = {sum[0], lo[W-1:1]};
        if (div_mode) begin
            if (!diff[W]) begin
                hi_next = diff[W-1:0];
                lo_next = {lo[W-2:0], 1'b1};
            end else begin
                hi_next = shifted[W-1:0];
                lo_next = {lo[W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - multi-cycle RV32M multiply/divide unit, one bit per cycle
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCODE_LENGTH-1:0] op,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic                     flush,
    output logic                     busy,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    ALUResult
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    state_e        state;
    muldiv_op_e    op_r;
    logic          neg_res;
    logic          neg_rem;
    logic [CW-1:0] count;
    logic [W-1:0]  hi_r;
    logic [W-1:0]  lo_r;
    logic [W-1:0]  b_r;

    muldiv_op_e    op_in;
    logic          a_neg_in;
    logic          b_neg_in;
    logic [W-1:0]  a_mag_in;
    logic [W-1:0]  b_mag_in;
    logic          ovf_in;
    logic          special;
    logic [W-1:0]  special_result;

    logic [W-1:0]   hi_next;
    logic [W-1:0]   lo_next;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   fix_result;

    assign op_in = muldiv_op_e'(op[2:0]);

    // Operand magnitudes and the short-circuit results for divide-by-zero and signed overflow.
    always_comb begin
        a_neg_in       = a_signed(op_in) & SrcA[W-1];
        b_neg_in       = b_signed(op_in) & SrcB[W-1];
        a_mag_in       = a_neg_in ? -SrcA : SrcA;
        b_mag_in       = b_neg_in ? -SrcB : SrcB;
        ovf_in         = (op_in inside {OP_DIV, OP_REM}) &&
                         (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == {W{1'b1}});
        special        = 1'b0;
        special_result = '0;
        if (is_div(op_in)) begin
            if (SrcB == '0) begin
                special        = 1'b1;
                special_result = is_rem(op_in) ? SrcA : {W{1'b1}};
            end else if (ovf_in) begin
                special        = 1'b1;
                special_result = is_rem(op_in) ? '0 : SrcA;
            end
        end
    end

    alu_muldiv_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .div_mode (is_div(op_r)),
        .hi       (hi_r),
        .lo       (lo_r),
        .operand  (b_r),
        .hi_next  (hi_next),
        .lo_next  (lo_next)
    );

    // Sign correction of the unsigned magnitudes and final result selection.
    always_comb begin
        prod_fix = neg_res ? -{hi_r, lo_r} : {hi_r, lo_r};
        quot_fix = neg_res ? -lo_r : lo_r;
        rem_fix  = neg_rem ? -hi_r : hi_r;
        case (op_r)
            OP_MUL:                      fix_result = prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*W-1:W];
            OP_DIV, OP_DIVU:             fix_result = quot_fix;
            default:                     fix_result = rem_fix;
        endcase
    end

    // Control FSM with registered handshake/status outputs and the iterating datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            op_r      <= OP_MUL;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            count     <= '0;
            hi_r      <= '0;
            lo_r      <= '0;
            b_r       <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            ALUResult <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid && !flush) begin
                        op_r     <= op_in;
                        neg_res  <= a_neg_in ^ b_neg_in;
                        neg_rem  <= a_neg_in;
                        hi_r     <= '0;
                        lo_r     <= a_mag_in;
                        b_r      <= b_mag_in;
                        count    <= CW'(W);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (special) begin
                            ALUResult <= special_result;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        hi_r  <= hi_next;
                        lo_r  <= lo_next;
                        count <= count - 1'b1;
                        if (count == CW'(1)) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        ALUResult <= fix_result;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - self-checking bench for alu_muldiv with a reference model
module tb_alu_muldiv;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        flush;
    logic        busy;
    logic        out_valid;
    logic [31:0] ALUResult;

    int          checks;
    int          failures;
    int          ov_count;
    logic [31:0] last_exp;

    alu_muldiv #(
        .DATA_WIDTH(32),
        .OPCODE_LENGTH(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .flush     (flush),
        .busy      (busy),
        .out_valid (out_valid),
        .ALUResult (ALUResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts result strobes; sampled before the edge's updates land.
    always @(posedge clk) begin
        if (reset) ov_count <= ov_count;
        else if (out_valid) ov_count <= ov_count + 1;
    end

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa;
        logic [63:0] xb;
        logic [63:0] p;
        int          sa;
        int          sb;
        logic        ovf;
        xa  = (o == 3'd1 || o == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        xb  = (o == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        p   = xa * xb;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                else if (ovf) return a;
                else return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                else return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                else if (ovf) return 32'd0;
                else return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                else return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Called at a falling edge; returns at the falling edge where out_valid is seen (or on timeout).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        op       = o;
        SrcA     = a;
        SrcB     = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = ALUResult;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        op       = 3'd0;
        SrcA     = 32'd0;
        SrcB     = 32'd0;
        ov_count = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            failures++;
            $display("FAIL reset_flags got=%b want=100", {in_ready, busy, out_valid});
        end
        checks++;
        if (ALUResult !== 32'd0) begin
            failures++;
            $display("FAIL reset_result got=%h want=00000000", ALUResult);
        end
        last_exp = 32'd0;
    endtask

    task automatic test_reset_mid_calc();
        int ov0;
        int c;
        ov0      = ov_count;
        op       = 3'd5;
        SrcA     = 32'd100;
        SrcB     = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        c = 1;
        while (c < 10) begin
            @(negedge clk);
            c++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b100 || ALUResult !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_calc flags=%b res=%h want flags=100 res=00000000",
                     {in_ready, busy, out_valid}, ALUResult);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (ov_count - ov0 !== 0) begin
            failures++;
            $display("FAIL reset_mid_calc_strobes got=%0d want=0", ov_count - ov0);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  t_op [15];
        logic [31:0] t_a  [15];
        logic [31:0] t_b  [15];
        logic [31:0] t_r  [15];
        int          t_l  [15];
        logic [31:0] res;
        int          lat;
        t_op = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5, 3'd7,
                 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
        t_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7,
                 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
        t_b  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFD,
                 32'd2, 32'd2, 32'd7, 32'd7,
                 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        t_r  = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
                 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd5};
        t_l  = '{34, 34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1, 1, 1};
        for (int i = 0; i < 15; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], res, lat);
            checks++;
            if (res !== t_r[i] || lat != t_l[i]) begin
                failures++;
                $display("FAIL directed_%0d op=%0d a=%h b=%h got res=%h lat=%0d want res=%h lat=%0d",
                         i, t_op[i], t_a[i], t_b[i], res, lat, t_r[i], t_l[i]);
            end
            last_exp = t_r[i];
        end
        @(negedge clk);
        checks++;
        if (ALUResult !== last_exp) begin
            failures++;
            $display("FAIL result_hold got=%h want=%h", ALUResult, last_exp);
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] exp_r;
        int          lat;
        int          exp_l;
        int          kind;
        for (int i = 0; i < 60; i++) begin
            o    = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = $urandom;
            kind = $urandom_range(0, 7);
            if (kind == 0) b = 32'd0;
            else if (kind == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (kind == 2) begin
                a = 32'($urandom_range(0, 300)) - 32'd150;
                b = 32'($urandom_range(1, 20)) - 32'd10;
                if (b == 0) b = 32'd3;
            end
            exp_r = ref_model(o, a, b);
            exp_l = ref_latency(o, a, b);
            run_op(o, a, b, res, lat);
            checks++;
            if (res !== exp_r || lat != exp_l) begin
                failures++;
                $display("FAIL random_%0d op=%0d a=%h b=%h got res=%h lat=%0d want res=%h lat=%0d",
                         i, o, a, b, res, lat, exp_r, exp_l);
            end
            last_exp = exp_r;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int          lat;
        run_op(3'd0, 32'd12345, 32'd678, res, lat);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done_flags got ready=%b busy=%b want ready=0 busy=1", in_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle_flags got ready=%b busy=%b want ready=1 busy=0", in_ready, busy);
        end
        run_op(3'd7, 32'd12345, 32'd678, res, lat);
        checks++;
        if (res !== 32'd141 || lat != 34) begin
            failures++;
            $display("FAIL b2b_second got res=%h lat=%0d want res=0000008d lat=34", res, lat);
        end
        last_exp = 32'd141;
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int          lat;
        int          ov0;
        int          c;
        @(negedge clk);
        ov0      = ov_count;
        in_valid = 1'b1;
        flush    = 1'b1;
        op       = 3'd5;
        SrcA     = 32'd50;
        SrcB     = 32'd5;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_idle_block got busy=%b ready=%b want busy=0 ready=1", busy, in_ready);
        end
        op       = 3'd0;
        SrcA     = 32'hDEAD_BEEF;
        SrcB     = 32'h1234_5678;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        c = 1;
        while (c < 20) begin
            @(negedge clk);
            c++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || ALUResult !== last_exp) begin
            failures++;
            $display("FAIL flush_calc got busy=%b res=%h want busy=0 res=%h", busy, ALUResult, last_exp);
        end
        run_op(3'd5, 32'd9, 32'd3, res, lat);
        repeat (40) @(negedge clk);
        checks++;
        if (res !== 32'd3 || lat != 34 || ov_count - ov0 != 1) begin
            failures++;
            $display("FAIL flush_then_divu got res=%h lat=%0d strobes=%0d want res=00000003 lat=34 strobes=1",
                     res, lat, ov_count - ov0);
        end
        last_exp = 32'd3;
    endtask

    task automatic test_hold_request();
        int ov0;
        int lat;
        ov0      = ov_count;
        op       = 3'd5;
        SrcA     = 32'd100;
        SrcB     = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        in_valid = 1'b0;
        checks++;
        if (ALUResult !== 32'd14 || lat != 34) begin
            failures++;
            $display("FAIL hold_request got res=%h lat=%0d want res=0000000e lat=34", ALUResult, lat);
        end
        repeat (45) @(negedge clk);
        checks++;
        if (ov_count - ov0 != 1) begin
            failures++;
            $display("FAIL hold_request_once got strobes=%0d want=1", ov_count - ov0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_reset_mid_calc();
        test_directed();
        test_back_to_back();
        test_flush();
        test_hold_request();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
